// File: rtl/md5_match_array.sv
// md5_match_array: tags candidates issued to a pipelined md5core and checks each returned digest
// against NUM_TARGETS targets, reporting the first hit. Optional: MD5_MATCH_ARRAY_STOP_ON_MATCH_EN.
module md5_match_array #(
  parameter int unsigned MSG_WIDTH   = 152,
  parameter int unsigned NUM_TARGETS = 4,
  parameter int unsigned TAG_DEPTH   = 128,
  parameter int unsigned SEQ_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [SEQ_WIDTH-1:0]       num_msgs,
  input  logic [128*NUM_TARGETS-1:0] target_hash,
  input  logic [MSG_WIDTH-1:0]       msg_in,
  input  logic                       msg_valid,
  output logic                       msg_ready,
  output logic [MSG_WIDTH-1:0]       md5_msg,
  output logic                       md5_msg_valid,
  input  logic [31:0]                a_ret,
  input  logic [31:0]                b_ret,
  input  logic [31:0]                c_ret,
  input  logic [31:0]                d_ret,
  input  logic [MSG_WIDTH-1:0]       md5_msg_ret,
  input  logic                       md5_msg_ret_valid,
  output logic                       busy,
  output logic                       done,
  output logic                       match,
  output logic [3:0]                 match_idx,
  output logic [SEQ_WIDTH-1:0]       match_seq,
  output logic [MSG_WIDTH-1:0]       match_msg,
  output logic [31:0]                hash_count,
  output logic                       err_underflow
);

  localparam int unsigned AW = $clog2(TAG_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state_q, state_d;
  logic [SEQ_WIDTH-1:0] num_q, issued_q, returned_q;
  logic [SEQ_WIDTH-1:0] tag_mem [TAG_DEPTH];
  logic [AW:0]          wr_ptr_q, rd_ptr_q;
  logic                 fifo_empty, fifo_full;
  logic                 accept, ret_live, pop, underflow, stop_issue;
  logic                 hit;
  logic [3:0]           hit_idx;
  logic [127:0]         digest;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

`ifdef MD5_MATCH_ARRAY_STOP_ON_MATCH_EN
  assign stop_issue = match;
`else
  assign stop_issue = 1'b0;
`endif

  assign msg_ready = (state_q == RUN) && !fifo_full && (issued_q < num_q) && !stop_issue;
  assign accept    = msg_valid && msg_ready;
  assign ret_live  = md5_msg_ret_valid && (state_q != IDLE);
  assign pop       = ret_live && !fifo_empty;
  assign underflow = ret_live && fifo_empty;
  assign digest    = {a_ret, b_ret, c_ret, d_ret};

  // Scan upward and keep the first equal slot so the lowest index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NUM_TARGETS; i++) begin
      if (!hit && (digest == target_hash[128*i +: 128])) begin
        hit     = 1'b1;
        hit_idx = i[3:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN: begin
        busy = 1'b1;
        if ((issued_q == num_q) || stop_issue) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (returned_q == issued_q) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) tag_mem[wr_ptr_q[AW-1:0]] <= issued_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      num_q         <= '0;
      issued_q      <= '0;
      returned_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      md5_msg       <= '0;
      md5_msg_valid <= 1'b0;
      match         <= 1'b0;
      match_idx     <= '0;
      match_seq     <= '0;
      match_msg     <= '0;
      hash_count    <= '0;
      err_underflow <= 1'b0;
    end else begin
      state_q       <= state_d;
      md5_msg_valid <= accept;
      if (accept) md5_msg <= msg_in;
      if ((state_q == IDLE) && start) begin
        num_q         <= num_msgs;
        issued_q      <= '0;
        returned_q    <= '0;
        match         <= 1'b0;
        match_idx     <= '0;
        match_seq     <= '0;
        match_msg     <= '0;
        hash_count    <= '0;
        err_underflow <= 1'b0;
      end
      if (accept) begin
        issued_q <= issued_q + 1'b1;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + 1'b1;
        returned_q <= returned_q + 1'b1;
      end
      if (ret_live)  hash_count    <= hash_count + 32'd1;
      if (underflow) err_underflow <= 1'b1;
      // An underflowed result has no tag, so it is counted but never compared.
      if (pop && hit && !match) begin
        match     <= 1'b1;
        match_idx <= hit_idx;
        match_seq <= tag_mem[rd_ptr_q[AW-1:0]];
        match_msg <= md5_msg_ret;
      end
    end
  end

endmodule

// File: tb/tb_md5_match_array.sv
// Scoreboard bench for md5_match_array: the bench models md5core with a latency queue and
// checks issued messages and end-of-run results from a separate monitor process.
module tb_md5_match_array;

  localparam int MW = 152;
  localparam logic [127:0] ABC_MD5 = 128'h900150983cd24fb0d6963f7d28e17f72;
  localparam logic [MW-1:0] M_ABC = 152'h616263;
  localparam logic [MW-1:0] M_XYZ = 152'h78797a;
  localparam logic [MW-1:0] M_QQQ = 152'h717171;
  localparam logic [MW-1:0] M_DEF = 152'h646566;

  logic          clk = 1'b0;
  logic          reset, start, msg_valid, msg_ready, md5_msg_valid, md5_msg_ret_valid;
  logic [15:0]   num_msgs;
  logic [511:0]  target_hash;
  logic [MW-1:0] msg_in, md5_msg, md5_msg_ret, match_msg;
  logic [31:0]   a_ret, b_ret, c_ret, d_ret, hash_count;
  logic          busy, done, match, err_underflow;
  logic [3:0]    match_idx;
  logic [15:0]   match_seq;

  md5_match_array #(.MSG_WIDTH(MW), .NUM_TARGETS(4), .TAG_DEPTH(4), .SEQ_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .num_msgs(num_msgs), .target_hash(target_hash),
    .msg_in(msg_in), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .md5_msg(md5_msg), .md5_msg_valid(md5_msg_valid),
    .a_ret(a_ret), .b_ret(b_ret), .c_ret(c_ret), .d_ret(d_ret),
    .md5_msg_ret(md5_msg_ret), .md5_msg_ret_valid(md5_msg_ret_valid),
    .busy(busy), .done(done), .match(match), .match_idx(match_idx), .match_seq(match_seq),
    .match_msg(match_msg), .hash_count(hash_count), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          m;
    logic [3:0]    idx;
    logic [15:0]   seq;
    logic [MW-1:0] msg;
    logic [31:0]   hc;
    logic          uf;
  } res_t;
  typedef struct {
    logic [MW-1:0] msg;
    int            due;
  } core_t;

  res_t          exp_res[$];
  logic [MW-1:0] exp_iss[$];
  core_t         core_q[$];
  int            errors = 0, checks = 0, cycle = 0, done_seen = 0;
  int            lat = 2, release_n = 0;
  bit            core_hold = 0, uf_arm = 0, uf_pend = 0;

  function automatic logic [127:0] dig(input logic [MW-1:0] m);
    if (m == M_ABC) return ABC_MD5;
    return m[127:0] ^ 128'h5a5a5a5a_5a5a5a5a_5a5a5a5a_5a5a5a5a;
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // md5core stand-in: returns each issued message after 'lat' cycles, in order.
  initial begin
    md5_msg_ret_valid = 1'b0;
    md5_msg_ret = '0;
    {a_ret, b_ret, c_ret, d_ret} = '0;
    forever begin
      @(negedge clk);
      cycle++;
      md5_msg_ret_valid = 1'b0;
      if (uf_pend) begin
        md5_msg_ret_valid = 1'b1;
        md5_msg_ret = M_ABC;
        {a_ret, b_ret, c_ret, d_ret} = dig(M_ABC);
        uf_pend = 0;
      end else if (core_q.size() > 0 && core_q[0].due <= cycle && (!core_hold || release_n > 0)) begin
        core_t e;
        e = core_q.pop_front();
        md5_msg_ret_valid = 1'b1;
        md5_msg_ret = e.msg;
        {a_ret, b_ret, c_ret, d_ret} = dig(e.msg);
        if (core_hold) release_n--;
        if (uf_arm) begin
          uf_pend = 1;
          uf_arm = 0;
        end
      end
      if (md5_msg_valid) core_q.push_back('{md5_msg, cycle + lat});
    end
  end

  // Monitor: compares the issued stream and the result fields at each done pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (md5_msg_valid) begin
          if (exp_iss.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL issue_unexpected: got md5_msg %0h expected no issue", md5_msg);
          end else chk("md5_msg", md5_msg, exp_iss.pop_front());
        end
        if (done) begin
          done_seen++;
          if (exp_res.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done_unexpected: got done=1 expected no done");
          end else begin
            res_t r;
            r = exp_res.pop_front();
            chk("match", match, r.m);
            chk("match_idx", match_idx, r.idx);
            chk("match_seq", match_seq, r.seq);
            chk("match_msg", match_msg, r.msg);
            chk("hash_count", hash_count, r.hc);
            chk("err_underflow", err_underflow, r.uf);
            chk("busy_at_done", busy, 1'b0);
          end
        end
      end
    end
  end

  task automatic run_start(input logic [15:0] n);
    @(negedge clk);
    num_msgs = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [MW-1:0] m);
    int k = 0;
    msg_in = m;
    msg_valid = 1'b1;
    while (!msg_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got msg_ready=0 for %0d cycles expected 1", k);
    end else exp_iss.push_back(m);
    @(negedge clk);
    msg_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int k = 0;
    while (done_seen < target && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (done_seen < target) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d runs done expected %0d", done_seen, target);
    end
    @(negedge clk);
  endtask

  initial begin
    int k;
    reset = 1'b1; start = 1'b0; num_msgs = '0; msg_in = '0; msg_valid = 1'b0;
    target_hash = {128'h3333, ABC_MD5, 128'h2222, 128'h1111};
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_match", match, 1'b0);
    chk("rst_match_idx", match_idx, 4'd0);
    chk("rst_match_seq", match_seq, 16'd0);
    chk("rst_match_msg", match_msg, '0);
    chk("rst_hash_count", hash_count, 32'd0);
    chk("rst_err_underflow", err_underflow, 1'b0);
    chk("rst_md5_msg_valid", md5_msg_valid, 1'b0);
    chk("rst_msg_ready", msg_ready, 1'b0);

    // Basic run: "abc" matches slot 2 at sequence 1.
    lat = 2;
    exp_res.push_back('{1'b1, 4'd2, 16'd1, M_ABC, 32'd3, 1'b0});
    run_start(16'd3);
    send(M_XYZ);
    send(M_ABC);
    send(M_QQQ);
    wait_done(1);

    // Empty run: done three cycles after the start cycle, nothing issued.
    exp_res.push_back('{1'b0, 4'd0, 16'd0, '0, 32'd0, 1'b0});
    @(negedge clk);
    num_msgs = 16'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (!done && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("done_latency", 32'(k), 32'd3);
    wait_done(2);

    // Tag FIFO full with depth 4; a start while busy must not disturb the run.
    target_hash = {128'h4444, 128'h3333, 128'h2222, 128'h1111};
    core_hold = 1; release_n = 0; lat = 1;
    exp_res.push_back('{1'b0, 4'd0, 16'd0, '0, 32'd6, 1'b0});
    run_start(16'd6);
    send(152'h10); send(152'h11); send(152'h12); send(152'h13);
    msg_in = 152'h14;
    msg_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ready_when_full", msg_ready, 1'b0);
      if (i == 1) begin
        start = 1'b1;
        num_msgs = 16'd9;
      end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    release_n = 1;
    send(152'h14);
    chk("ready_refull", msg_ready, 1'b0);
    core_hold = 0;
    send(152'h15);
    wait_done(3);

    // First match sticks: slot 0 at seq 0, later slot 3 hit at seq 4 is ignored.
    target_hash = {dig(M_DEF), 128'h2222, 128'h1111, ABC_MD5};
    lat = 3;
    exp_res.push_back('{1'b1, 4'd0, 16'd0, M_ABC, 32'd5, 1'b0});
    run_start(16'd5);
    send(M_ABC); send(M_XYZ); send(M_QQQ); send(152'h77); send(M_DEF);
    wait_done(4);

    // Underflow in DRAIN: extra result carrying a matching digest is counted, not compared.
    target_hash = {128'h3333, 128'h2222, ABC_MD5, 128'h1111};
    lat = 0; uf_arm = 1;
    exp_res.push_back('{1'b0, 4'd0, 16'd0, '0, 32'd2, 1'b1});
    run_start(16'd1);
    send(M_XYZ);
    wait_done(5);

    // Next start clears the sticky underflow flag.
    lat = 3;
    exp_res.push_back('{1'b0, 4'd0, 16'd0, '0, 32'd1, 1'b0});
    run_start(16'd1);
    send(M_QQQ);
    wait_done(6);

    repeat (5) @(negedge clk);
    chk("issue_queue_empty", 32'(exp_iss.size()), 32'd0);
    chk("result_queue_empty", 32'(exp_res.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected $finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
